// File: rtl/fifo_uart_tx.sv
// Serial transmitter that drains a show-ahead FIFO: one 8N1-style frame
// (start, bitWidth data bits LSB first, stop) per popped entry.
module fifo_uart_tx #(
  parameter int bitWidth     = 8,
  parameter int clocksPerBit = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                empty,
  input  logic [bitWidth-1:0] popData,
  output logic                pop,
  output logic                txd,
  output logic                busy
);

  localparam int CNT_W = (clocksPerBit > 1) ? $clog2(clocksPerBit) : 1;
  localparam int BIT_W = (bitWidth > 1) ? $clog2(bitWidth) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(clocksPerBit - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(bitWidth - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [bitWidth-1:0] shift_q, shift_d;
  logic                txd_d;
  logic                baud_last;

  assign baud_last = (baud_q == BAUD_LAST);
  assign busy      = (state_q != IDLE);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = popData;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next frame when the FIFO still has data.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = popData;
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (!reset) pop = 1'b0;

    // The line level is computed from the next state so txd can be a flop.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd     <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd     <= txd_d;
    end
  end

endmodule
